instr_fetch: RTL and testbench

Instruction fetch unit for the downsampling processor: holds the program counter, reads 8-bit instructions from instruction memory through a request/acknowledge handshake, and delivers each fetched instruction to the instruction register input with a one-cycle valid strobe. It is the producer feeding the instruction register and sits between the controller (fetch requests, jumps) and the instruction memory.

---
 rtl/instr_fetch_if.sv | 37 +++
 rtl/instr_fetch.sv | 165 ++++++++++++++++
 tb/tb_instr_fetch.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_if
// Instruction memory bus between the fetch unit and the instruction memory.
//
// Signals:
//   im_addr   fetch unit -> memory  instruction address, stable while im_rd is high
//   im_rd     fetch unit -> memory  read request, held until acknowledged
//   im_ack    memory -> fetch unit  acknowledge; im_rdata is valid in the same cycle
//   im_rdata  memory -> fetch unit  instruction word
//
// Modports:
//   master  the fetch unit (drives address/request)
//   slave   the instruction memory (drives acknowledge/data)
// -----------------------------------------------------------------------------
interface instr_fetch_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] im_addr;
    logic              im_rd;
    logic              im_ack;
    logic [DATA_W-1:0] im_rdata;

    modport master (
        output im_addr,
        output im_rd,
        input  im_ack,
        input  im_rdata
    );

    modport slave (
        input  im_addr,
        input  im_rd,
        output im_ack,
        output im_rdata
    );
endinterface

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Instruction fetch unit. Holds the program counter, reads one instruction at a
// time from instruction memory over a request/acknowledge handshake and hands
// each fetched word to the instruction register with a one-cycle valid strobe.
// A jump (pc_load) that arrives while a fetch is outstanding is remembered and
// applied when the fetch ends; the word returned for that fetch is discarded.
//
// Ports:
//   clk          clock, all logic on the rising edge
//   RST          synchronous active-low reset
//   fetch_req    controller asks for the next instruction (sampled only in IDLE)
//   pc_load      jump strobe
//   pc_load_val  jump target
//   im           instruction memory bus (instr_fetch_if.master)
//   instr        last fetched instruction
//   instr_valid  one-cycle pulse: instr carries a new word
//   pc           program counter, address of the next fetch
//   busy         high while a fetch is outstanding
//   fetch_err    one-cycle pulse when a fetch is abandoned after TIMEOUT cycles
//
// Optional feature (macro FETCH_TIMEOUT_EN):
//   Defined   - an outstanding fetch is abandoned after TIMEOUT cycles without
//               im_ack; the TIMEOUT parameter exists only in this build.
//   Undefined - a fetch waits indefinitely and fetch_err is held low.
// -----------------------------------------------------------------------------
module instr_fetch #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
`ifdef FETCH_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 16
`endif
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              fetch_req,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_load_val,
    instr_fetch_if.master     im,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              fetch_err
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

    state_t            state;
    logic              jmp_pend;
    logic [ADDR_W-1:0] jmp_tgt;

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CNT_W-1:0] wait_cnt;
`endif

    // A fetch that ends while a jump is known (latched earlier or arriving in
    // the ending cycle itself) redirects the pc instead of delivering data.
    // The jump seen in the ending cycle is the latest one, so it wins.
    logic              redirect;
    logic [ADDR_W-1:0] redirect_tgt;

    // NOTE: every signal written in always_comb gets a value on every path,
    // here by straight assignment, so no latch can be inferred.
    always_comb begin
        redirect     = pc_load | jmp_pend;
        redirect_tgt = pc_load ? pc_load_val : jmp_tgt;
    end

    // NOTE: all state below is a flop and uses non-blocking assignments only,
    // so every read in this block sees the value from before the edge.
    always_ff @(posedge clk) begin
        if (!RST) begin
            // NOTE: the jump target register is reset too even though it is
            // only read behind jmp_pend; it is a single register, not an
            // array, and a known value keeps simulation free of X.
            state       <= S_IDLE;
            pc          <= '0;
            im.im_addr  <= '0;
            im.im_rd    <= 1'b0;
            instr       <= '0;
            instr_valid <= 1'b0;
            busy        <= 1'b0;
            fetch_err   <= 1'b0;
            jmp_pend    <= 1'b0;
            jmp_tgt     <= '0;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt    <= '0;
`endif
        end else begin
            // Strobes default low; they are raised for exactly one cycle.
            instr_valid <= 1'b0;
            fetch_err   <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (pc_load) begin
                        pc <= pc_load_val;
                    end
                    if (fetch_req) begin
                        // A jump in the same cycle makes the target the first
                        // address fetched.
                        im.im_addr <= pc_load ? pc_load_val : pc;
                        im.im_rd   <= 1'b1;
                        busy       <= 1'b1;
                        state      <= S_REQ;
`ifdef FETCH_TIMEOUT_EN
                        wait_cnt   <= '0;
`endif
                    end
                end

                S_REQ: begin
                    // im_addr and im_rd are simply not written here, so they
                    // stay stable until the fetch ends.
                    if (pc_load) begin
                        jmp_pend <= 1'b1;
                        jmp_tgt  <= pc_load_val;
                    end

                    if (im.im_ack) begin
                        if (redirect) begin
                            pc <= redirect_tgt;
                        end else begin
                            instr       <= im.im_rdata;
                            instr_valid <= 1'b1;
                            pc          <= pc + ADDR_W'(1);
                        end
                        im.im_rd <= 1'b0;
                        busy     <= 1'b0;
                        jmp_pend <= 1'b0;
                        state    <= S_IDLE;
                    end
`ifdef FETCH_TIMEOUT_EN
                    // wait_cnt counts completed wait cycles; this cycle would
                    // be the TIMEOUT-th, so give up. An ack in this same cycle
                    // is handled above and takes priority.
                    else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        if (redirect) begin
                            pc <= redirect_tgt;
                        end
                        fetch_err <= 1'b1;
                        im.im_rd  <= 1'b0;
                        busy      <= 1'b0;
                        jmp_pend  <= 1'b0;
                        state     <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
`endif
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
// Self-checking bench for instr_fetch. A transaction-level model of the fetch
// unit predicts every output after each clock edge; directed scenarios add
// hand-computed expectations, followed by a long randomized run with random
// memory latency, jumps, stray acknowledges and occasional resets.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
`ifdef FETCH_TIMEOUT_EN
    localparam int TIMEOUT = 16;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              fetch_req;
    logic              pc_load;
    logic [ADDR_W-1:0] pc_load_val;
    logic [DATA_W-1:0] instr;
    logic              instr_valid;
    logic [ADDR_W-1:0] pc;
    logic              busy;
    logic              fetch_err;

    instr_fetch_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    instr_fetch #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
`ifdef FETCH_TIMEOUT_EN
        ,
        .TIMEOUT(TIMEOUT)
`endif
    ) u_dut (
        .clk        (clk),
        .RST        (rst_n),
        .fetch_req  (fetch_req),
        .pc_load    (pc_load),
        .pc_load_val(pc_load_val),
        .im         (bus),
        .instr      (instr),
        .instr_valid(instr_valid),
        .pc         (pc),
        .busy       (busy),
        .fetch_err  (fetch_err)
    );

    always #5 clk = ~clk;

    // Instruction memory contents.
    logic [7:0] mem [256];

    // Behavioural model: "is a fetch outstanding", which address it targets,
    // the jump to apply when it ends, and the visible outputs.
    bit         m_fetching;
    logic [7:0] m_pc;
    logic [7:0] m_addr;
    logic [7:0] m_instr;
    bit         m_valid;
    bit         m_err;
    bit         m_jump;
    logic [7:0] m_jump_to;
    int         m_waited;

    int n_checks = 0;
    int n_passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_passed++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Outcome of one clock edge given the inputs applied before it.
    task automatic model_step(input bit r, input bit fr, input bit pl,
                              input logic [7:0] plv, input bit ak);
        m_valid = 1'b0;
        m_err   = 1'b0;
        if (!r) begin
            m_fetching = 1'b0;
            m_pc       = 8'h00;
            m_addr     = 8'h00;
            m_instr    = 8'h00;
            m_jump     = 1'b0;
        end else if (!m_fetching) begin
            if (pl) m_pc = plv;
            if (fr) begin
                m_addr     = m_pc;
                m_fetching = 1'b1;
                m_waited   = 0;
            end
        end else begin
            if (pl) begin
                m_jump    = 1'b1;
                m_jump_to = plv;
            end
            if (ak) begin
                if (m_jump) begin
                    m_pc = m_jump_to;
                end else begin
                    m_instr = mem[m_addr];
                    m_valid = 1'b1;
                    m_pc    = m_addr + 8'd1;
                end
                m_fetching = 1'b0;
                m_jump     = 1'b0;
            end else begin
                m_waited++;
`ifdef FETCH_TIMEOUT_EN
                if (m_waited == TIMEOUT) begin
                    if (m_jump) m_pc = m_jump_to;
                    m_err      = 1'b1;
                    m_fetching = 1'b0;
                    m_jump     = 1'b0;
                end
`endif
            end
        end
    endtask

    // Apply inputs (called just after a falling edge), run one rising edge,
    // then compare every output against the model at the next falling edge.
    task automatic tick(input bit r, input bit fr, input bit pl,
                        input logic [7:0] plv, input bit ak);
        rst_n        = r;
        fetch_req    = fr;
        pc_load      = pl;
        pc_load_val  = plv;
        bus.im_ack   = ak;
        bus.im_rdata = ak ? mem[bus.im_addr] : 8'($urandom);
        model_step(r, fr, pl, plv, ak);
        @(posedge clk);
        @(negedge clk);
        check("im_rd",       bus.im_rd,   m_fetching);
        check("busy",        busy,        m_fetching);
        check("pc",          pc,          m_pc);
        check("instr",       instr,       m_instr);
        check("instr_valid", instr_valid, m_valid);
        check("fetch_err",   fetch_err,   m_err);
        if (m_fetching) check("im_addr", bus.im_addr, m_addr);
    endtask

    initial begin
        int rd_cycles;
        int guard;
        logic [7:0] mem_ff;

        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[0] = 8'hA5;
        mem_ff = mem[255];

        rst_n        = 1'b0;
        fetch_req    = 1'b0;
        pc_load      = 1'b0;
        pc_load_val  = 8'h00;
        bus.im_ack   = 1'b0;
        bus.im_rdata = 8'h00;
        @(negedge clk);

        // Reset state.
        tick(0, 0, 0, 8'h00, 0);
        tick(0, 1, 1, 8'h77, 1);
        check("reset_pc",    pc,          8'h00);
        check("reset_im_rd", bus.im_rd,   1'b0);
        check("reset_instr", instr,       8'h00);
        check("reset_valid", instr_valid, 1'b0);

        // Fetch from 0 acknowledged on the third request cycle.
        tick(1, 1, 0, 8'h00, 0);
        rd_cycles = 0;
        for (int i = 0; i < 3; i++) begin
            if (bus.im_rd) rd_cycles++;
            tick(1, 0, 0, 8'h00, (i == 2));
        end
        check("s1_rd_cycles", rd_cycles,   3);
        check("s1_instr",     instr,       8'hA5);
        check("s1_valid",     instr_valid, 1'b1);
        check("s1_pc",        pc,          8'h01);
        check("s1_rd_low",    bus.im_rd,   1'b0);
        tick(1, 0, 0, 8'h00, 0);
        check("s1_valid_one", instr_valid, 1'b0);

        // Jump to 0xFF, then two zero-wait fetches wrap the pc.
        tick(1, 0, 1, 8'hFF, 1);
        tick(1, 1, 0, 8'h00, 1);
        check("s2_addr_ff", bus.im_addr, 8'hFF);
        tick(1, 0, 0, 8'h00, 1);
        check("s2_instr_ff", instr, mem_ff);
        check("s2_pc_wrap",  pc,    8'h00);
        tick(1, 1, 0, 8'h00, 1);
        check("s2_addr_00", bus.im_addr, 8'h00);
        tick(1, 0, 0, 8'h00, 1);
        check("s2_instr_00", instr, 8'hA5);
        check("s2_pc_end",   pc,    8'h01);

        // Jump during an outstanding fetch: data discarded, pc := target.
        tick(1, 1, 0, 8'h00, 0);
        tick(1, 0, 1, 8'h40, 0);
        tick(1, 0, 0, 8'h00, 1);
        check("s3_no_valid", instr_valid, 1'b0);
        check("s3_instr",    instr,       8'hA5);
        check("s3_pc",       pc,          8'h40);
        tick(1, 1, 0, 8'h00, 0);
        check("s3_next_addr", bus.im_addr, 8'h40);
        tick(1, 0, 0, 8'h00, 1);

        // fetch_req and pc_load together in IDLE.
        tick(1, 1, 1, 8'h20, 0);
        check("s4_addr", bus.im_addr, 8'h20);
        tick(1, 0, 0, 8'h00, 1);
        check("s4_pc",    pc,          8'h21);
        check("s4_valid", instr_valid, 1'b1);

        // Reset in the middle of a fetch.
        tick(1, 1, 0, 8'h00, 0);
        tick(1, 0, 0, 8'h00, 0);
        tick(0, 0, 0, 8'h00, 0);
        check("s5_rd",   bus.im_rd, 1'b0);
        check("s5_busy", busy,      1'b0);
        check("s5_pc",   pc,        8'h00);
        tick(1, 0, 0, 8'h00, 1);
        check("s5_no_valid", instr_valid, 1'b0);
        check("s5_rd_idle",  bus.im_rd,   1'b0);

`ifdef FETCH_TIMEOUT_EN
        // No acknowledge: fetch abandoned after TIMEOUT request cycles.
        tick(1, 1, 0, 8'h00, 0);
        rd_cycles = 0;
        guard     = 0;
        while (bus.im_rd && guard < 40) begin
            rd_cycles++;
            guard++;
            tick(1, 0, 0, 8'h00, 0);
        end
        check("s6_rd_cycles", rd_cycles, TIMEOUT);
        check("s6_err",       fetch_err, 1'b1);
        check("s6_pc",        pc,        8'h00);
        check("s6_busy",      busy,      1'b0);
        tick(1, 0, 0, 8'h00, 0);
        check("s6_err_one", fetch_err, 1'b0);
`else
        guard = 0;
`endif

        // Randomized run.
        for (int n = 0; n < 3000; n++) begin
            bit         r;
            bit         fr;
            bit         pl;
            logic [7:0] plv;
            bit         ak;
            r   = ($urandom_range(0, 99) != 0);
            fr  = 1'($urandom_range(0, 1));
            pl  = ($urandom_range(0, 5) == 0);
            plv = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            ak  = ($urandom_range(0, 2) == 0);
            tick(r, fr, pl, plv, ak);
        end

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
